// File: rtl/dsp48a1_dot_ctrl.sv
// Streaming dot-product controller for a DSP48A1 slice configured as a MAC.
// Feeds operand pairs, sequences OPMODE, and captures the sum once the last product reaches P.
module dsp48a1_dot_ctrl #(
    parameter int LEN         = 8,
    parameter int LATENCY     = 4,
    parameter int OPMODE_SKEW = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [17:0] IN_A,
    input  logic [17:0] IN_B,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [47:0] OUT_P,
    output logic [17:0] DSP_A,
    output logic [17:0] DSP_B,
    output logic [7:0]  DSP_OPMODE,
    output logic        DSP_CE,
    input  logic [47:0] DSP_P
);

    localparam int CNT_W = $clog2(LEN + 1);
    localparam logic [7:0] OP_FIRST = 8'b0000_0001;
    localparam logic [7:0] OP_ACC   = 8'b0000_1001;

    typedef enum logic [1:0] {
        S_FEED   = 2'd0,
        S_DRAIN  = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [CNT_W-1:0]            r_count;
    logic [CNT_W-1:0]            w_count_nxt;
    logic [LATENCY:0]            r_tag_vld;
    logic [LATENCY:0]            r_tag_last;
    logic [OPMODE_SKEW:0][7:0]   r_op_pipe;
    logic [17:0]                 r_dsp_a;
    logic [17:0]                 r_dsp_b;
    logic                        r_ce;
    logic                        r_in_ready;
    logic                        r_out_valid;
    logic [47:0]                 r_out_p;
    logic                        w_accept;
    logic                        w_first;
    logic                        w_last;
    logic                        w_mature;
    logic                        w_capture;
    logic                        w_release;
    logic [7:0]                  w_op_item;

    assign w_accept  = IN_VALID && r_in_ready;
    assign w_first   = (r_count == {CNT_W{1'b0}});
    assign w_last    = (r_count == CNT_W'(LEN - 1));
    assign w_mature  = r_tag_vld[LATENCY] && r_tag_last[LATENCY];
    assign w_release = (r_state == S_RESULT) && r_out_valid && OUT_READY;
    // Only the first accepted pair of a vector clears Z; bubbles and later pairs accumulate.
    assign w_op_item = (w_accept && w_first) ? OP_FIRST : OP_ACC;

    assign IN_READY   = r_in_ready;
    assign OUT_VALID  = r_out_valid;
    assign OUT_P      = r_out_p;
    assign DSP_A      = r_dsp_a;
    assign DSP_B      = r_dsp_b;
    assign DSP_CE     = r_ce;
    assign DSP_OPMODE = r_op_pipe[OPMODE_SKEW];

    // Next-state and sample-count logic
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_capture   = 1'b0;
        case (r_state)
            S_FEED: begin
                if (w_accept) begin
                    w_count_nxt = r_count + CNT_W'(1);
                    if (w_last) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_state_nxt = S_FEED;
                    end
                end else begin
                    w_state_nxt = S_FEED;
                end
            end
            S_DRAIN: begin
                if (w_mature) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESULT;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_RESULT: begin
                if (w_release) begin
                    w_state_nxt = S_FEED;
                    w_count_nxt = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt = S_RESULT;
                end
            end
            default: begin
                w_state_nxt = S_FEED;
                w_count_nxt = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and count registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_FEED;
            r_count <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Slice drive, opmode delay line, tag pipe and result capture
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ce        <= 1'b0;
            r_in_ready  <= 1'b0;
            r_dsp_a     <= 18'd0;
            r_dsp_b     <= 18'd0;
            r_op_pipe   <= '0;
            r_tag_vld   <= '0;
            r_tag_last  <= '0;
            r_out_valid <= 1'b0;
            r_out_p     <= 48'd0;
        end else begin
            r_ce       <= 1'b1;
            r_in_ready <= (w_state_nxt == S_FEED);
            if (w_accept) begin
                r_dsp_a <= IN_A;
                r_dsp_b <= IN_B;
            end else begin
                r_dsp_a <= 18'd0;
                r_dsp_b <= 18'd0;
            end
            // Stage 0 is aligned with DSP_A; the tap OPMODE_SKEW stages later meets the M stage.
            r_op_pipe[0] <= w_op_item;
            for (int i = 1; i <= OPMODE_SKEW; i++) begin
                r_op_pipe[i] <= r_op_pipe[i-1];
            end
            r_tag_vld  <= {r_tag_vld[LATENCY-1:0], w_accept};
            r_tag_last <= {r_tag_last[LATENCY-1:0], w_accept && w_last};
            if (w_capture) begin
                r_out_p     <= DSP_P;
                r_out_valid <= 1'b1;
            end else if (w_release) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_out_valid;
            end
        end
    end

endmodule

// File: tb/tb_dsp48a1_dot_ctrl.sv
// Bench for dsp48a1_dot_ctrl: behavioural DSP48A1 slice model, table vectors, random vectors
// against an arithmetic dot-product reference, and hand-written back-pressure and reset sequences.
module tb_dsp48a1_dot_ctrl;
    localparam int LEN = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        OUT_READY = 1'b1;
    logic [17:0] IN_A = 18'd0;
    logic [17:0] IN_B = 18'd0;
    logic        IN_READY;
    logic        OUT_VALID;
    logic [47:0] OUT_P;
    logic [17:0] DSP_A;
    logic [17:0] DSP_B;
    logic [7:0]  DSP_OPMODE;
    logic        DSP_CE;
    logic [47:0] DSP_P;

    dsp48a1_dot_ctrl #(.LEN(LEN), .LATENCY(4), .OPMODE_SKEW(2)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_A(IN_A), .IN_B(IN_B), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_P(OUT_P), .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_OPMODE(DSP_OPMODE),
        .DSP_CE(DSP_CE), .DSP_P(DSP_P)
    );

    always #5 CLK = ~CLK;

    // Slice model: A0/B0, A1/B1, M and P registers plus OPMODE register.
    logic [17:0] m_a0 = 18'd0, m_a1 = 18'd0, m_b0 = 18'd0, m_b1 = 18'd0;
    logic [35:0] m_m  = 36'd0;
    logic [7:0]  m_op = 8'd0;
    logic [47:0] m_p  = 48'd0;
    logic [47:0] m_x, m_z;
    assign m_x   = (m_op[1:0] == 2'b01) ? {{12{m_m[35]}}, m_m} : 48'd0;
    assign m_z   = (m_op[3:2] == 2'b10) ? m_p : 48'd0;
    assign DSP_P = m_p;
    always @(posedge CLK) begin
        if (DSP_CE) begin
            m_a0 <= DSP_A;
            m_b0 <= DSP_B;
            m_a1 <= m_a0;
            m_b1 <= m_b0;
            m_m  <= 36'($signed(m_a1) * $signed(m_b1));
            m_op <= DSP_OPMODE;
            m_p  <= m_z + m_x;
        end
    end

    int cyc_cnt = 0;
    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    int op1_total = 0;
    int op1_edge  = 0;
    always @(negedge CLK) begin
        if (DSP_OPMODE == 8'h01) begin
            op1_total <= op1_total + 1;
            op1_edge  <= cyc_cnt;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] dot_ref(input logic [3:0][17:0] a, input logic [3:0][17:0] b);
        longint s;
        s = 0;
        for (int i = 0; i < LEN; i++) s += longint'($signed(a[i])) * longint'($signed(b[i]));
        return s[47:0];
    endfunction

    // gap: 0 back-to-back, 1 IN_VALID every other cycle, 2 random
    task automatic feed(input logic [3:0][17:0] a, input logic [3:0][17:0] b, input int gap,
                        input int n, output int first_edge, output int last_edge);
        int   i;
        int   guard;
        logic rdy;
        bit   tog;
        i = 0; guard = 0; tog = 1'b0; first_edge = -1; last_edge = -1;
        while (i < n && guard < 200) begin
            @(negedge CLK);
            guard++;
            tog = ~tog;
            if ((gap == 1 && tog) || (gap == 2 && $urandom_range(0, 1) == 0)) begin
                IN_VALID = 1'b0;
            end else begin
                IN_VALID = 1'b1;
                IN_A = a[i];
                IN_B = b[i];
            end
            rdy = IN_READY;
            if (IN_VALID && rdy) begin
                if (i == 0) first_edge = cyc_cnt + 1;
                last_edge = cyc_cnt + 1;
                i++;
            end
        end
        @(negedge CLK);
        IN_VALID = 1'b0;
        if (i < n) begin
            n_checks++; n_fail++;
            $display("FAIL feed_timeout: accepted %0d, expected %0d", i, n);
        end
    endtask

    task automatic run_vec(input string name, input logic [3:0][17:0] a, input logic [3:0][17:0] b,
                           input int gap, input logic [47:0] exp);
        int f, l, v, ops0;
        bit rdy_bad;
        v = -1; rdy_bad = 1'b0;
        ops0 = op1_total;
        feed(a, b, gap, LEN, f, l);
        check({name, "_ready_low"}, 48'(IN_READY), 48'd0);
        for (int k = 0; k < 60; k++) begin
            @(negedge CLK);
            if (OUT_VALID) begin
                v = cyc_cnt;
                break;
            end
            if (IN_READY) rdy_bad = 1'b1;
        end
        if (v < 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s_timeout: OUT_VALID never rose, expected within 60 cycles", name);
        end else begin
            check({name, "_p"}, OUT_P, exp);
            check({name, "_ready_drain"}, 48'(rdy_bad), 48'd0);
            check({name, "_op1_count"}, 48'(op1_total - ops0), 48'd1);
            check({name, "_op1_time"}, 48'(op1_edge - f), 48'd2);
            if (OUT_READY) begin
                check({name, "_latency"}, 48'(v - l), 48'd5);
                @(negedge CLK);
                check({name, "_valid_drop"}, 48'(OUT_VALID), 48'd0);
                check({name, "_ready_back"}, 48'(IN_READY), 48'd1);
            end
        end
    endtask

    typedef struct {
        string            name;
        logic [3:0][17:0] a;
        logic [3:0][17:0] b;
        int               gap;
        logic [47:0]      exp;
    } vec_t;

    vec_t             tbl[6];
    logic [3:0][17:0] ra, rb;
    int               df, dl;

    initial begin
        tbl[0].name = "seq";    tbl[0].a = {18'd7, 18'd5, 18'd3, 18'd1};
        tbl[0].b = {18'd8, 18'd6, 18'd4, 18'd2};         tbl[0].gap = 0; tbl[0].exp = 48'd100;
        tbl[1].name = "neg";    tbl[1].a = {4{18'h3FFFF}};
        tbl[1].b = {4{18'd1}};                            tbl[1].gap = 0; tbl[1].exp = 48'hFFFF_FFFF_FFFC;
        tbl[2].name = "maxpos"; tbl[2].a = {4{18'h1FFFF}};
        tbl[2].b = {4{18'h1FFFF}};                        tbl[2].gap = 0; tbl[2].exp = 48'd68718428164;
        tbl[3].name = "gapped"; tbl[3].a = {18'd7, 18'd5, 18'd3, 18'd1};
        tbl[3].b = {18'd8, 18'd6, 18'd4, 18'd2};         tbl[3].gap = 1; tbl[3].exp = 48'd100;
        tbl[4].name = "b2b";    tbl[4].a = {4{18'd2}};
        tbl[4].b = {4{18'd2}};                            tbl[4].gap = 0; tbl[4].exp = 48'd16;
        tbl[5].name = "maxneg"; tbl[5].a = {4{18'h20000}};
        tbl[5].b = {4{18'h20000}};                        tbl[5].gap = 0; tbl[5].exp = 48'd68719476736;

        repeat (3) @(negedge CLK);
        check("rst_dsp_a", 48'(DSP_A), 48'd0);
        check("rst_dsp_b", 48'(DSP_B), 48'd0);
        check("rst_opmode", 48'(DSP_OPMODE), 48'd0);
        check("rst_ce", 48'(DSP_CE), 48'd0);
        check("rst_out_valid", 48'(OUT_VALID), 48'd0);
        check("rst_out_p", OUT_P, 48'd0);
        check("rst_in_ready", 48'(IN_READY), 48'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("ce_after_rst", 48'(DSP_CE), 48'd1);

        for (int t = 0; t < 6; t++) run_vec(tbl[t].name, tbl[t].a, tbl[t].b, tbl[t].gap, tbl[t].exp);

        for (int r = 0; r < 8; r++) begin
            for (int j = 0; j < LEN; j++) begin
                ra[j] = 18'($urandom());
                rb[j] = 18'($urandom());
            end
            run_vec("rand", ra, rb, int'($urandom_range(0, 2)), dot_ref(ra, rb));
        end

        // Consumer stalls for 10 cycles with the result pending
        OUT_READY = 1'b0;
        run_vec("stall", tbl[0].a, tbl[0].b, 0, 48'd100);
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            check("stall_valid", 48'(OUT_VALID), 48'd1);
            check("stall_p", OUT_P, 48'd100);
            check("stall_ready", 48'(IN_READY), 48'd0);
        end
        OUT_READY = 1'b1;
        @(negedge CLK);
        check("stall_release_valid", 48'(OUT_VALID), 48'd0);
        check("stall_release_ready", 48'(IN_READY), 48'd1);

        // Reset after two of four pairs
        ra = {4{18'd1}};
        feed(ra, ra, 0, 2, df, dl);
        RST = 1'b1;
        #1;
        check("mid_rst_dsp_a", 48'(DSP_A), 48'd0);
        check("mid_rst_dsp_b", 48'(DSP_B), 48'd0);
        check("mid_rst_opmode", 48'(DSP_OPMODE), 48'd0);
        check("mid_rst_ce", 48'(DSP_CE), 48'd0);
        check("mid_rst_out_valid", 48'(OUT_VALID), 48'd0);
        check("mid_rst_out_p", OUT_P, 48'd0);
        check("mid_rst_in_ready", 48'(IN_READY), 48'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        run_vec("after_rst", ra, ra, 0, 48'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
